addsat_stage: RTL

ADDSAT_STAGE -- requirements
Module: addsat_stage

---
 rtl/addsat_stage_if.sv | 23 ++
 rtl/addsat_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/addsat_stage_if.sv
// Sum/result stream bundle between the pipelined adder, the saturation stage
// and its downstream consumer. The stage itself sits on the slave side.
interface addsat_stage_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_carry, out_ready,
    output out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_carry, out_ready,
    input  out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/addsat_stage.sv
// Saturating/wrapping post-adder stage with a 2-entry result buffer and
// overflow/drop statistics. The head entry drives the outputs from registers.
module addsat_stage #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sat_en,
  input  logic                 clear,
  addsat_stage_if.slave        bus,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 drop_sticky
);

  localparam logic [WIDTH-1:0]     SAT_VALUE = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // Second FIFO slot; the head slot is the output register set itself.
  logic             tail_valid;
  logic [WIDTH-1:0] tail_data;
  logic             tail_ovf;

  logic             res_ovf_c;
  logic [WIDTH-1:0] res_data_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  logic             head_valid_d;
  logic [WIDTH-1:0] head_data_d;
  logic             head_ovf_d;
  logic             tail_valid_d;
  logic [WIDTH-1:0] tail_data_d;
  logic             tail_ovf_d;

  logic [CNT_WIDTH-1:0] ovf_count_d;
  logic [CNT_WIDTH-1:0] drop_count_d;
  logic                 drop_sticky_d;

  // Result formation and handshake decode.
  always_comb begin
    res_data_c = bus.in_data;
    res_ovf_c  = bus.in_carry;
    if (sat_en && bus.in_carry) begin
      res_data_c = SAT_VALUE;
    end
    pop_c  = bus.out_valid && bus.out_ready;
    push_c = bus.in_valid && (!tail_valid || pop_c);
    drop_c = bus.in_valid && tail_valid && !pop_c;
  end

  // FIFO next state: tail is only ever occupied while head is occupied.
  always_comb begin
    head_valid_d = bus.out_valid;
    head_data_d  = bus.out_data;
    head_ovf_d   = bus.out_ovf;
    tail_valid_d = tail_valid;
    tail_data_d  = tail_data;
    tail_ovf_d   = tail_ovf;

    if (pop_c) begin
      if (tail_valid) begin
        head_valid_d = 1'b1;
        head_data_d  = tail_data;
        head_ovf_d   = tail_ovf;
        tail_valid_d = push_c;
        if (push_c) begin
          tail_data_d = res_data_c;
          tail_ovf_d  = res_ovf_c;
        end
      end else begin
        head_valid_d = push_c;
        if (push_c) begin
          head_data_d = res_data_c;
          head_ovf_d  = res_ovf_c;
        end
      end
    end else if (push_c) begin
      if (!bus.out_valid) begin
        head_valid_d = 1'b1;
        head_data_d  = res_data_c;
        head_ovf_d   = res_ovf_c;
      end else begin
        tail_valid_d = 1'b1;
        tail_data_d  = res_data_c;
        tail_ovf_d   = res_ovf_c;
      end
    end
  end

  // Statistics: saturating counters, clear wins over any same-cycle event.
  always_comb begin
    ovf_count_d   = ovf_count;
    drop_count_d  = drop_count;
    drop_sticky_d = drop_sticky;
    if (clear) begin
      ovf_count_d   = '0;
      drop_count_d  = '0;
      drop_sticky_d = 1'b0;
    end else begin
      if (push_c && bus.in_carry && (ovf_count != CNT_MAX)) begin
        ovf_count_d = ovf_count + CNT_WIDTH'(1);
      end
      if (drop_c) begin
        drop_sticky_d = 1'b1;
        if (drop_count != CNT_MAX) begin
          drop_count_d = drop_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
      tail_valid    <= 1'b0;
      tail_data     <= '0;
      tail_ovf      <= 1'b0;
      ovf_count     <= '0;
      drop_count    <= '0;
      drop_sticky   <= 1'b0;
    end else begin
      bus.out_valid <= head_valid_d;
      bus.out_data  <= head_data_d;
      bus.out_ovf   <= head_ovf_d;
      tail_valid    <= tail_valid_d;
      tail_data     <= tail_data_d;
      tail_ovf      <= tail_ovf_d;
      ovf_count     <= ovf_count_d;
      drop_count    <= drop_count_d;
      drop_sticky   <= drop_sticky_d;
    end
  end

endmodule
